// File: rtl/seq_subtractor_if.sv
// Operand/result handshake bundle for seq_subtractor: valid/ready in, valid/ready out.
interface seq_subtractor_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             zero;
  logic             ovf;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout, zero, ovf
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout, zero, ovf
  );
endinterface

// File: rtl/seq_subtractor.sv
// Multi-cycle a - b - bin, one SLICE-bit slice per clock, LSB first, borrow registered between slices.
// Optional signed saturation on overflow when SEQ_SUB_SAT_EN is defined.
module seq_subtractor #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SLICE = 8
) (
  input logic         clk,
  input logic         rst_n,
  seq_subtractor_if.slave bus
);
  localparam int unsigned N_SLICES = WIDTH / SLICE;
  localparam int unsigned CNT_W    = (N_SLICES > 1) ? $clog2(N_SLICES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               borrow_q, borrow_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic               bout_q, bout_d;
  logic               zero_q, zero_d;
  logic               ovf_q, ovf_d;

  logic [SLICE:0]     slice_full;
  logic [WIDTH-1:0]   diff_raw;
  logic [WIDTH-1:0]   diff_fin;
  logic               ovf_raw;
  logic               last_slice;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      borrow_q <= borrow_d;
      a_q      <= a_d;
      b_q      <= b_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
    end
  end

  always_comb begin
    // One extra MSB on each operand: bit SLICE of the result is the slice borrow-out.
    slice_full = {1'b0, a_q[cnt_q*SLICE +: SLICE]}
               - {1'b0, b_q[cnt_q*SLICE +: SLICE]}
               - {{SLICE{1'b0}}, borrow_q};
    diff_raw = diff_q;
    diff_raw[cnt_q*SLICE +: SLICE] = slice_full[SLICE-1:0];
    ovf_raw    = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff_raw[WIDTH-1] != a_q[WIDTH-1]);
    last_slice = (cnt_q == CNT_W'(N_SLICES - 1));
`ifdef SEQ_SUB_SAT_EN
    if (ovf_raw) begin
      diff_fin = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      diff_fin = diff_raw;
    end
`else
    diff_fin = diff_raw;
`endif
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    borrow_d = borrow_q;
    a_d      = a_q;
    b_d      = b_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d      = bus.a;
          b_d      = bus.b;
          borrow_d = bus.bin;
          diff_d   = '0;
          cnt_d    = '0;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        borrow_d = slice_full[SLICE];
        cnt_d    = cnt_q + CNT_W'(1);
        diff_d   = diff_raw;
        if (last_slice) begin
          diff_d  = diff_fin;
          bout_d  = slice_full[SLICE];
          zero_d  = (diff_fin == '0);
          ovf_d   = ovf_raw;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.diff      = diff_q;
  assign bus.bout      = bout_q;
  assign bus.zero      = zero_q;
  assign bus.ovf       = ovf_q;
endmodule
